// File: rtl/fx2_link_pkg.sv
// Shared types for the FX2 slave-FIFO write-port arbiter.
// Latency: n/a (types only).  Backpressure: n/a.
package fx2_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        REPLY,
        RPKTEND,
        DATA,
        DFLUSH
    } state_t;

    typedef enum logic [1:0] {
        TGT_NONE,
        TGT_REPLY,
        TGT_DATA,
        TGT_DFLUSH
    } target_t;

    localparam logic [1:0] EP_REPLY_DEFAULT = 2'd2;
    localparam logic [1:0] EP_DATA_DEFAULT  = 2'd0;

    function automatic state_t tgt_state(input target_t t);
        case (t)
            TGT_REPLY:  return REPLY;
            TGT_DATA:   return DATA;
            TGT_DFLUSH: return DFLUSH;
            default:    return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pkt_flush_timer.sv
// Tracks bytes in the open data packet and idle time since the last data write.
// Latency: flush_due is registered state, valid the cycle after the idle limit is reached.
// Backpressure: none; counts every cycle, cleared by data writes or a forced commit.
module pkt_flush_timer #(
    parameter int unsigned PKT_SIZE     = 512,
    parameter int unsigned FLUSH_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic data_wr,
    input  logic flush_clr,
    output logic flush_due
);

    localparam int CW = $clog2(PKT_SIZE);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(PKT_SIZE - 1);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

    logic [CW-1:0] data_cnt;
    logic [FW-1:0] flush_cnt;

    // The FX2 commits full packets itself, so the byte count simply wraps.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_cnt <= '0;
        end else if (flush_clr) begin
            data_cnt <= '0;
        end else if (data_wr) begin
            data_cnt <= (data_cnt == CNT_LAST) ? '0 : data_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flush_cnt <= '0;
        end else if (data_wr || data_cnt == '0) begin
            flush_cnt <= '0;
        end else if (flush_cnt != FLUSH_LAST) begin
            flush_cnt <= flush_cnt + 1'b1;
        end
    end

    assign flush_due = (flush_cnt == FLUSH_LAST) && (data_cnt != '0);

endmodule

// File: rtl/fx2_link_arbiter.sv
// Muxes reply (strict priority, PKTEND-committed) and data bytes onto the FX2 write port.
// Latency: strobes combinational from state; endpoint switch costs one decision plus TURN_CYCLES dead cycles.
// Backpressure: fifo_full stalls writes/commits in place; sources hold rdy until ack.
module fx2_link_arbiter
    import fx2_link_pkg::*;
#(
    parameter logic [1:0]  REPLY_EP     = EP_REPLY_DEFAULT,
    parameter logic [1:0]  DATA_EP      = EP_DATA_DEFAULT,
    parameter int unsigned TURN_CYCLES  = 2,
    parameter int unsigned PKT_SIZE     = 512,
    parameter int unsigned FLUSH_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       reply_rdy,
    input  logic [7:0] reply,
    input  logic       reply_end,
    output logic       reply_ack,
    input  logic       data_rdy,
    input  logic [7:0] data,
    output logic       data_ack,
    input  logic       fifo_full,
    output logic [1:0] fifo_adr,
    output logic [7:0] fifo_data,
    output logic       fifo_wr,
    output logic       fifo_pktend
);

    state_t     state_q, state_d;
    target_t    pend_q, pend_d;
    logic [1:0] adr_q, adr_d;
    logic [7:0] turn_q, turn_d;
    logic       flush_due;
    logic       flush_clr;
    target_t    tgt;
    logic [1:0] tgt_ep;

    pkt_flush_timer #(
        .PKT_SIZE     (PKT_SIZE),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .data_wr   (data_ack),
        .flush_clr (flush_clr),
        .flush_due (flush_due)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q  <= TGT_NONE;
            adr_q   <= DATA_EP;
            turn_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            adr_q   <= adr_d;
            turn_q  <= turn_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        adr_d       = adr_q;
        turn_d      = turn_q;
        tgt         = TGT_NONE;
        tgt_ep      = adr_q;
        reply_ack   = 1'b0;
        data_ack    = 1'b0;
        fifo_wr     = 1'b0;
        fifo_pktend = 1'b0;
        fifo_data   = '0;
        flush_clr   = 1'b0;

        case (state_q)
            IDLE: begin
                if (reply_rdy) begin
                    tgt    = TGT_REPLY;
                    tgt_ep = REPLY_EP;
                end else if (data_rdy) begin
                    tgt    = TGT_DATA;
                    tgt_ep = DATA_EP;
                end else if (flush_due) begin
                    tgt    = TGT_DFLUSH;
                    tgt_ep = DATA_EP;
                end
                // FULL reflects the old endpoint until the FX2 settles on the new address.
                if (tgt != TGT_NONE) begin
                    if (tgt_ep == adr_q) begin
                        state_d = tgt_state(tgt);
                    end else begin
                        adr_d   = tgt_ep;
                        turn_d  = 8'(TURN_CYCLES);
                        pend_d  = tgt;
                        state_d = TURN;
                    end
                end
            end
            TURN: begin
                if (turn_q != '0) begin
                    turn_d = turn_q - 8'd1;
                end
                if (turn_q <= 8'd1) begin
                    state_d = tgt_state(pend_q);
                    pend_d  = TGT_NONE;
                end
            end
            REPLY: begin
                if (reply_rdy && !fifo_full) begin
                    reply_ack = 1'b1;
                    fifo_wr   = 1'b1;
                    fifo_data = reply;
                    if (reply_end) begin
                        state_d = RPKTEND;
                    end
                end
            end
            RPKTEND: begin
                if (!fifo_full) begin
                    fifo_pktend = 1'b1;
                    state_d     = IDLE;
                end
            end
            DATA: begin
                // A waiting reply takes the port at the next byte boundary.
                if (reply_rdy || !data_rdy) begin
                    state_d = IDLE;
                end else if (!fifo_full) begin
                    data_ack  = 1'b1;
                    fifo_wr   = 1'b1;
                    fifo_data = data;
                end
            end
            DFLUSH: begin
                if (!fifo_full) begin
                    fifo_pktend = 1'b1;
                    flush_clr   = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fifo_adr = adr_q;

endmodule

// File: tb/tb_fx2_link_arbiter.sv
// Randomised and directed bench for fx2_link_arbiter against a transaction-level reference model.
module tb_fx2_link_arbiter;

    localparam logic [1:0] REP_EP = 2'd2;
    localparam logic [1:0] DAT_EP = 2'd0;
    localparam int TURN  = 2;
    localparam int PKT   = 512;
    localparam int FLUSH = 64;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       reply_rdy = 1'b0;
    logic [7:0] reply = '0;
    logic       reply_end = 1'b0;
    logic       reply_ack;
    logic       data_rdy = 1'b0;
    logic [7:0] data = '0;
    logic       data_ack;
    logic       fifo_full = 1'b0;
    logic [1:0] fifo_adr;
    logic [7:0] fifo_data;
    logic       fifo_wr;
    logic       fifo_pktend;

    always #5 clk = ~clk;

    fx2_link_arbiter dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .reply_rdy   (reply_rdy),
        .reply       (reply),
        .reply_end   (reply_end),
        .reply_ack   (reply_ack),
        .data_rdy    (data_rdy),
        .data        (data),
        .data_ack    (data_ack),
        .fifo_full   (fifo_full),
        .fifo_adr    (fifo_adr),
        .fifo_data   (fifo_data),
        .fifo_wr     (fifo_wr),
        .fifo_pktend (fifo_pktend)
    );

    int total = 0;
    int bad   = 0;

    // Source queues: what each producer still has to deliver ({end, byte} for replies).
    logic [8:0] rq[$];
    logic [7:0] dq[$];

    bit rtaken, dtaken, need_end, hold_flush;
    int rgap, dgap, full_pct, hold_cnt, hold_len, stall_at;
    int rcnt, dcnt, rpe, dpe, partial, idle, age, cyc;
    int last_flush_sz, last_flush_idle, r_first, adr_chg;
    int rpush, dpush;
    logic [1:0] prev_adr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        dq.delete();
        rtaken = 0; dtaken = 0; need_end = 0; hold_flush = 0;
        hold_cnt = 0; partial = 0; idle = 0; age = TURN; prev_adr = DAT_EP;
    endtask

    task automatic drive();
        if (hold_cnt > 0) begin
            fifo_full = 1'b1;
            hold_cnt--;
        end else begin
            fifo_full = ($urandom_range(99) < full_pct);
        end
        if (!reply_rdy || rtaken) begin
            rtaken = 0;
            if (rq.size() > 0 && $urandom_range(99) >= rgap) begin
                reply_rdy = 1'b1;
                {reply_end, reply} = rq[0];
            end else begin
                reply_rdy = 1'b0; reply_end = 1'b0; reply = '0;
            end
        end
        if (!data_rdy || dtaken) begin
            dtaken = 0;
            if (dq.size() > 0 && $urandom_range(99) >= dgap) begin
                data_rdy = 1'b1;
                data = dq[0];
            end else begin
                data_rdy = 1'b0; data = '0;
            end
        end
    endtask

    task automatic monitor();
        logic       wr, pe;
        logic [1:0] adr;
        wr  = fifo_wr;
        pe  = fifo_pktend;
        adr = fifo_adr;
        chk("adr_legal", adr == REP_EP || adr == DAT_EP, 1);
        if (adr != prev_adr) begin
            age = 0;
            adr_chg = cyc;
        end else if (age < 1000) begin
            age++;
        end
        prev_adr = adr;
        chk("reply_ack", reply_ack, wr && adr == REP_EP);
        chk("data_ack", data_ack, wr && adr == DAT_EP);
        chk("wr_and_pktend", wr && pe, 0);
        chk("strobe_when_full", (wr || pe) && fifo_full, 0);
        chk("strobe_in_turn", (wr || pe) && age < TURN, 0);
        if (!wr) chk("fd_idle_zero", fifo_data, 0);
        if (wr && adr == DAT_EP) idle = 0; else idle++;

        if (need_end) begin
            if (!wr) chk("reply_pktend", pe, !fifo_full);
            if (pe) begin
                chk("reply_pktend_adr", adr, REP_EP);
                need_end = 0;
                rpe++;
            end
        end else if (pe) begin
            chk("flush_adr", adr, DAT_EP);
            chk("flush_too_early", idle >= FLUSH, 1);
            chk("flush_empty_pkt", partial != 0, 1);
            last_flush_sz = partial;
            last_flush_idle = idle;
            partial = 0;
            dpe++;
        end

        if (wr && adr == REP_EP) begin
            chk("reply_src_rdy", reply_rdy, 1);
            chk("reply_before_commit", need_end, 0);
            chk("reply_q_nonempty", rq.size() != 0, 1);
            if (rq.size() != 0) begin
                chk("reply_byte", fifo_data, rq[0][7:0]);
                if (rq[0][8]) begin
                    need_end = 1;
                    hold_cnt = hold_len;
                end
                void'(rq.pop_front());
            end
            if (rcnt == 0) r_first = cyc;
            rtaken = 1;
            rcnt++;
            if (rcnt == stall_at) hold_cnt = 5;
        end
        if (wr && adr == DAT_EP) begin
            chk("data_src_rdy", data_rdy, 1);
            chk("data_while_reply", reply_rdy, 0);
            chk("data_before_commit", need_end, 0);
            chk("data_q_nonempty", dq.size() != 0, 1);
            if (dq.size() != 0) begin
                chk("data_byte", fifo_data, dq[0]);
                void'(dq.pop_front());
            end
            partial = (partial + 1) % PKT;
            dtaken = 1;
            dcnt++;
        end
        if (hold_flush && !wr && partial != 0 && idle == FLUSH - 1) begin
            hold_cnt = 10;
            hold_flush = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        cyc++;
        if (reset_n) monitor();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        reply_rdy = 1'b0; reply_end = 1'b0; reply = '0;
        data_rdy = 1'b0; data = '0; fifo_full = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("rst_wr", fifo_wr, 0);
            chk("rst_pktend", fifo_pktend, 0);
            chk("rst_reply_ack", reply_ack, 0);
            chk("rst_data_ack", data_ack, 0);
            chk("rst_adr", fifo_adr, DAT_EP);
            @(negedge clk);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        chk("rel_adr", fifo_adr, DAT_EP);
        chk("rel_wr", fifo_wr, 0);
    endtask

    task automatic drain(input string tag, input int maxc);
        int n = 0;
        while ((rq.size() != 0 || dq.size() != 0 || need_end || partial != 0 ||
                reply_rdy || data_rdy) && n < maxc) begin
            tick();
            n++;
        end
        chk(tag, n < maxc, 1);
    endtask

    initial begin
        int n;
        rgap = 0; dgap = 0; full_pct = 0; hold_len = 0; stall_at = -1;
        cyc = 0; rcnt = 0; dcnt = 0; rpe = 0; dpe = 0;
        last_flush_sz = 0; last_flush_idle = 0; r_first = 0; adr_chg = 0;
        do_reset();

        // Three-byte reply on an idle link.
        rq.push_back(9'h0A1); rq.push_back(9'h0A2); rq.push_back(9'h1A3);
        drain("t1_drain", 200);
        chk("t1_reply_acks", rcnt, 3);
        chk("t1_pktends", rpe, 1);
        chk("t1_dead_cycles", r_first - adr_chg, TURN);

        // 1030 back-to-back data bytes: two silent auto-commits and a 6-byte flush.
        dcnt = 0; dpe = 0;
        for (int i = 0; i < 1030; i++) dq.push_back(8'($urandom));
        drain("t2_drain", 3000);
        chk("t2_data_writes", dcnt, 1030);
        chk("t2_flushes", dpe, 1);
        chk("t2_flush_size", last_flush_sz, 6);
        chk("t2_flush_latency", last_flush_idle <= FLUSH + TURN + 3, 1);

        // FULL raised for 5 cycles after byte 2 of a 4-byte reply.
        rcnt = 0; rpe = 0; stall_at = 2;
        rq.push_back(9'h011); rq.push_back(9'h022); rq.push_back(9'h033); rq.push_back(9'h144);
        drain("t3_drain", 200);
        chk("t3_reply_acks", rcnt, 4);
        chk("t3_pktends", rpe, 1);
        stall_at = -1;

        // Reply preempts a data stream after byte 100; data resumes into the same packet.
        rcnt = 0; rpe = 0; dcnt = 0; dpe = 0;
        for (int i = 0; i < 150; i++) dq.push_back(8'(i));
        n = 0;
        while (dcnt < 100 && n < 1000) begin
            tick();
            n++;
        end
        chk("t4_reach_100", dcnt >= 100, 1);
        rq.push_back(9'h0C1); rq.push_back(9'h0C2); rq.push_back(9'h1C3);
        drain("t4_drain", 1000);
        chk("t4_reply_acks", rcnt, 3);
        chk("t4_reply_pktends", rpe, 1);
        chk("t4_data_writes", dcnt, 150);
        chk("t4_flushes", dpe, 1);
        chk("t4_flush_size", last_flush_sz, 150);

        // FULL held 10 cycles across the reply commit and across the flush.
        rpe = 0; dpe = 0; hold_len = 10;
        rq.push_back(9'h1EE);
        drain("t5_drain_r", 200);
        chk("t5_reply_pktends", rpe, 1);
        hold_len = 0; hold_flush = 1;
        for (int i = 0; i < 7; i++) dq.push_back(8'($urandom));
        drain("t5_drain_d", 500);
        chk("t5_flushes", dpe, 1);
        chk("t5_flush_size", last_flush_sz, 7);
        chk("t5_flush_held", last_flush_idle >= FLUSH + 10, 1);

        // Random mix of reply packets, data bursts, source gaps and FULL.
        rcnt = 0; dcnt = 0; rpush = 0; dpush = 0;
        rgap = 30; dgap = 20; full_pct = 15;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(1) == 1) begin
                int len = $urandom_range(6, 1);
                for (int b = 0; b < len; b++)
                    rq.push_back({(b == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
                rpush += len;
            end
            if ($urandom_range(9) < 7) begin
                int len = $urandom_range(40, 1);
                for (int b = 0; b < len; b++) dq.push_back(8'($urandom));
                dpush += len;
            end
            n = ($urandom_range(4) == 0) ? $urandom_range(150, 80) : $urandom_range(60, 5);
            repeat (n) tick();
        end
        drain("t6_drain", 5000);
        chk("t6_reply_bytes", rcnt, rpush);
        chk("t6_data_bytes", dcnt, dpush);
        rgap = 0; dgap = 0; full_pct = 0;

        // Reset asserted while byte 2 of a 5-byte reply is being acknowledged.
        rcnt = 0;
        for (int b = 0; b < 5; b++) rq.push_back({(b == 4) ? 1'b1 : 1'b0, 8'(8'h50 + b)});
        n = 0;
        while (rcnt < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("t7_reach_byte2", rcnt, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("t7_imm_wr", fifo_wr, 0);
        chk("t7_imm_reply_ack", reply_ack, 0);
        chk("t7_imm_pktend", fifo_pktend, 0);
        do_reset();
        rcnt = 0; rpe = 0;
        rq.push_back(9'h077); rq.push_back(9'h188);
        drain("t7_drain", 200);
        chk("t7_reply_acks", rcnt, 2);
        chk("t7_pktends", rpe, 1);
        chk("t7_dead_cycles", r_first - adr_chg, TURN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
